// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: a single full-adder cell walks the operands LSB-first,
// one bit per clock, and reports unsigned carry/borrow and signed overflow.
module serial_add_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_next_s;
    logic [WIDTH-1:0] result_r;
    logic [CNT_W-1:0] cnt_r;
    logic             c_r;
    logic             s_s;
    logic             c_next_s;
    logic             last_s;
    logic             busy_r;
    logic             done_r;
    logic             carry_r;
    logic             overflow_r;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Full-adder cell on the current LSBs and the sum register with the new bit at the MSB
    always_comb begin
        s_s        = a_sh_r[0] ^ b_sh_r[0] ^ c_r;
        c_next_s   = maj3(a_sh_r[0], b_sh_r[0], c_r);
        last_s     = (cnt_r == CNT_W'(WIDTH - 1));
        sum_next_s = sum_r >> 1;
        sum_next_s[WIDTH-1] = s_s;
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and output registers; results land on the last RUN edge so they
    // are already visible in the cycle done_o is high
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_sh_r     <= {WIDTH{1'b0}};
            b_sh_r     <= {WIDTH{1'b0}};
            sum_r      <= {WIDTH{1'b0}};
            result_r   <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            c_r        <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            carry_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        a_sh_r <= op_a_i;
                        b_sh_r <= sub_i ? ~op_b_i : op_b_i;
                        c_r    <= sub_i;
                        cnt_r  <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    a_sh_r <= a_sh_r >> 1;
                    b_sh_r <= b_sh_r >> 1;
                    sum_r  <= sum_next_s;
                    c_r    <= c_next_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        // c_r here is the carry into the MSB
                        result_r   <= sum_next_s;
                        carry_r    <= c_next_s;
                        overflow_r <= c_r ^ c_next_s;
                        done_r     <= 1'b1;
                    end else begin
                        done_r     <= 1'b0;
                    end
                end
                ST_DONE: done_r <= 1'b0;
                default: done_r <= 1'b0;
            endcase
        end
    end

    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign result_o   = result_r;
    assign carry_o    = carry_r;
    assign overflow_o = overflow_r;

endmodule
